nn_node_mac: RTL

Sequential multiply-accumulate neuron for the ANN datapath. It replaces the externally indexed, fixed-64-input node with a streaming, parametrised node. Each accepted beat carries one (data, coef) pair; after N_IN beats the node adds the bias, rescales, saturates and applies a selectable activation. The result is presented on a valid/ready output to the next layer.

---
 rtl/nn_pkg.sv | 36 +++
 rtl/nn_act_sat.sv | 42 ++++
 rtl/nn_node_mac.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and sizing helpers for the streaming MAC neuron.
package nn_pkg;

  typedef enum logic [1:0] {
    LINEAR  = 2'd0,
    RELU    = 2'd1,
    LEAKY   = 2'd2,
    LINEAR2 = 2'd3
  } act_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    DRAIN = 3'd2,
    ACT   = 3'd3,
    DONE  = 3'd4
  } node_state_e;

  // Headroom: full product width plus one bit per doubling of beats, plus bias.
  function automatic int acc_width(input int data_w, input int n_in);
    return 2 * data_w + $clog2(n_in) + 1;
  endfunction

  function automatic int cnt_width(input int n_in);
    return (n_in > 1) ? $clog2(n_in) : 1;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/nn_act_sat.sv
// Rescale the accumulator back to DATA_W fixed point, apply the activation
// at full width, then clamp to the signed DATA_W range.
module nn_act_sat
  import nn_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 39
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  act_e                     act_i,
  output logic        [DATA_W-1:0] data_o,
  output logic                     sat_o
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(DATA_W));
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(DATA_W));

  logic signed [ACC_W-1:0] r;
  logic signed [ACC_W-1:0] a;

  always_comb begin
    r = acc_i >>> FRAC_W;
    a = r;
    case (act_i)
      RELU:    if (r[ACC_W-1]) a = '0;
      LEAKY:   if (r[ACC_W-1]) a = r >>> 3;
      default: a = r;
    endcase

    data_o = a[DATA_W-1:0];
    sat_o  = 1'b0;
    if (a > MAX_V) begin
      data_o = MAX_V[DATA_W-1:0];
      sat_o  = 1'b1;
    end else if (a < MIN_V) begin
      data_o = MIN_V[DATA_W-1:0];
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/nn_node_mac.sv
// Streaming multiply-accumulate neuron: N_IN (data, coef) beats, plus bias,
// then rescale/activate/saturate, presented on a valid/ready output.
module nn_node_mac
  import nn_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int N_IN   = 64,
  parameter int ACC_W  = acc_width(DATA_W, N_IN)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic [1:0]        act_sel,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_coef,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  output logic              busy
);

  localparam int CNT_W  = cnt_width(N_IN);
  localparam int PROD_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);

  node_state_e state_q, state_d;

  logic        [CNT_W-1:0]  count_q, count_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic                     prod_v_q, prod_v_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  act_e                     act_q, act_d;
  logic        [DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;

  logic                     load;
  logic                     accept;
  logic signed [ACC_W-1:0]  bias_ext;
  logic        [DATA_W-1:0] as_data;
  logic                     as_sat;

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; load marks the cycle a new evaluation is armed
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid && (count_q == LAST)) state_d = DRAIN;
      end
      DRAIN: state_d = ACT;
      ACT:   state_d = DONE;
      DONE: begin
        if (out_ready) begin
          if (start) begin
            load    = 1'b1;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  assign accept   = in_ready & in_valid;
  assign bias_ext = ACC_W'($signed(bias));
  assign out_data = out_data_q;
  assign out_sat  = out_sat_q;

  // Datapath: product is registered one cycle ahead of the accumulate,
  // so the last beat lands in the accumulator during DRAIN.
  always_comb begin
    count_d    = count_q;
    prod_d     = prod_q;
    prod_v_d   = accept;
    acc_d      = acc_q;
    act_d      = act_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;

    if (load)        count_d = '0;
    else if (accept) count_d = count_q + CNT_W'(1);

    if (accept) prod_d = $signed(in_data) * $signed(in_coef);

    if (load)          acc_d = bias_ext <<< FRAC_W;
    else if (prod_v_q) acc_d = acc_q + ACC_W'(prod_q);

    if (load) act_d = act_e'(act_sel);

    if (state_q == ACT) begin
      out_data_d = as_data;
      out_sat_d  = as_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_q    <= '0;
      prod_q     <= '0;
      prod_v_q   <= 1'b0;
      acc_q      <= '0;
      act_q      <= LINEAR;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      prod_q     <= prod_d;
      prod_v_q   <= prod_v_d;
      acc_q      <= acc_d;
      act_q      <= act_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  nn_act_sat #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_act_sat (
    .acc_i  (acc_q),
    .act_i  (act_q),
    .data_o (as_data),
    .sat_o  (as_sat)
  );

endmodule
